vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter REZ_MAX_WIDTH, default 11: width of count maxima and position counters.
REQ-002 Parameter PULSE_WIDTH, default 8: width of sync pulse lengths.
REQ-003 Parameter MARGIN_WIDTH, default 8: width of all four margins.
REQ-004 Parameter SYNC_ACTIVE, default 0: level driven on H_sync/V_sync during the pulse.
REQ-005 Clk  input  1  system/pixel clock; all logic on rising edge.
REQ-006 Rst  input  1  asynchronous, active-low reset.
REQ-007 Load_config  input  1  one-cycle strobe; config inputs valid this cycle.
REQ-008 H_left_margin, H_right_margin, V_left_margin, V_right_margin  input  MARGIN_WIDTH each  porch lengths.
REQ-009 H_count_max, V_count_max  input  REZ_MAX_WIDTH each  last count value of line/frame.
REQ-010 H_sync_pulse, V_sync_pulse  input  PULSE_WIDTH each  sync lengths in clocks/lines.
REQ-011 H_sync, V_sync  output  1  sync pulses.
REQ-012 Display_enable  output  1  high on visible pixels.
REQ-013 H_pos, V_pos  output  REZ_MAX_WIDTH each  visible-pixel coordinates, 0 outside visible region.
REQ-014 Frame_start  output  1  one-cycle pulse at H_count=0, V_count=0.

Function
REQ-015 Shall keep H_count 0..H_count_max, wrapping to 0; V_count shall increment when H_count wraps, wrapping to 0 after V_count_max.
REQ-016 H_sync shall equal SYNC_ACTIVE while H_count < H_sync_pulse; V_sync likewise on V_count/V_sync_pulse.
REQ-017 Horizontal visible while H_sync_pulse+H_left_margin <= H_count <= H_count_max-H_right_margin; vertical analogously; Display_enable = both.
REQ-018 H_pos = H_count-(H_sync_pulse+H_left_margin) when visible, V_pos analogous.
REQ-019 All outputs registered: exactly one clock latency from counter state.
REQ-020 Load_config shall capture all eight inputs into a pending shadow set and set Pending; active set shall update only at frame end (H_count=H_count_max, V_count=V_count_max), then Pending clears.
REQ-021 Further Load_config while Pending shall overwrite the shadow set (last wins).
REQ-022 Load_config coinciding with frame end shall apply the new values at that boundary.
REQ-023 Margin/pulse sums computed at REZ_MAX_WIDTH+1 bits; no wrap in comparisons.

Reset
REQ-024 Rst low shall force counters to 0, H_sync/V_sync to ~SYNC_ACTIVE, Display_enable/Frame_start 0, H_pos/V_pos 0, Pending 0.
REQ-025 Active and shadow sets shall reset to 640x480: H 799/96/48/16, V 524/2/33/10 (count_max/pulse/left/right).
REQ-026 Reset mid-frame shall discard any pending config.

Configuration
REQ-027 Macro VGA_TIMING_CHECK_EN: when defined, a Load_config with H_sync_pulse+H_left_margin+H_right_margin > H_count_max (or vertical equivalent) shall be rejected, leaving shadow untouched, and output Config_err (1 bit) shall pulse one cycle.
REQ-028 Without VGA_TIMING_CHECK_EN, no check, no Config_err port; invalid sets yield Display_enable never high.

Structure
REQ-029 Width constants and 640x480 defaults shall live in the shared width-parameter package used by the config block.
REQ-030 One sub-module vga_axis_counter (count, sync, visible, pos), instantiated for H and V.

Verification
REQ-031 Reset release -> H_sync active for clocks 1..96 after first counter edge, Frame_start pulse at cycle 1, line length 800.
REQ-032 Load H 9/2/1/1, V 5/1/1/1 -> after current frame ends, H_sync active counts 0-1, Display_enable counts 3..8, H_pos 0..5.
REQ-033 Two Load_configs in one frame -> only second applied at boundary.
REQ-034 Load_config on the frame-end cycle -> new timing from next Frame_start.
REQ-035 Rst low mid-frame with Pending set -> 640x480 restored, pending dropped.
REQ-036 With VGA_TIMING_CHECK_EN, load H 9/6/3/3 -> Config_err pulse, timing unchanged.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared widths and the 640x480 power-on timing used by the vga_timing config block.
package vga_timing_pkg;

   localparam int unsigned RezMaxWidthDef = 11;
   localparam int unsigned PulseWidthDef  = 8;
   localparam int unsigned MarginWidthDef = 8;

   localparam int unsigned HCountMaxDef   = 799;
   localparam int unsigned HSyncPulseDef  = 96;
   localparam int unsigned HLeftMarginDef = 48;
   localparam int unsigned HRightMarginDef = 16;

   localparam int unsigned VCountMaxDef   = 524;
   localparam int unsigned VSyncPulseDef  = 2;
   localparam int unsigned VLeftMarginDef = 33;
   localparam int unsigned VRightMarginDef = 10;

   // True when sync plus both porches fit inside one line/frame.
   function automatic logic axis_fits(input int unsigned count_max, input int unsigned pulse,
                                      input int unsigned left, input int unsigned right);
      return (pulse + left + right) <= count_max;
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Configuration and timing-output bundle of vga_timing.
// Config_err is present only when VGA_TIMING_CHECK_EN is defined.
interface vga_timing_if #(
   parameter int unsigned REZ_MAX_WIDTH = vga_timing_pkg::RezMaxWidthDef,
   parameter int unsigned PULSE_WIDTH   = vga_timing_pkg::PulseWidthDef,
   parameter int unsigned MARGIN_WIDTH  = vga_timing_pkg::MarginWidthDef
);

   logic                     Load_config;
   logic [MARGIN_WIDTH-1:0]  H_left_margin;
   logic [MARGIN_WIDTH-1:0]  H_right_margin;
   logic [MARGIN_WIDTH-1:0]  V_left_margin;
   logic [MARGIN_WIDTH-1:0]  V_right_margin;
   logic [REZ_MAX_WIDTH-1:0] H_count_max;
   logic [REZ_MAX_WIDTH-1:0] V_count_max;
   logic [PULSE_WIDTH-1:0]   H_sync_pulse;
   logic [PULSE_WIDTH-1:0]   V_sync_pulse;

   logic                     H_sync;
   logic                     V_sync;
   logic                     Display_enable;
   logic [REZ_MAX_WIDTH-1:0] H_pos;
   logic [REZ_MAX_WIDTH-1:0] V_pos;
   logic                     Frame_start;
`ifdef VGA_TIMING_CHECK_EN
   logic                     Config_err;
`endif

   modport master (
      output Load_config, H_left_margin, H_right_margin, V_left_margin, V_right_margin,
             H_count_max, V_count_max, H_sync_pulse, V_sync_pulse,
      input  H_sync, V_sync, Display_enable, H_pos, V_pos, Frame_start
`ifdef VGA_TIMING_CHECK_EN
      , input Config_err
`endif
   );

   modport slave (
      input  Load_config, H_left_margin, H_right_margin, V_left_margin, V_right_margin,
             H_count_max, V_count_max, H_sync_pulse, V_sync_pulse,
      output H_sync, V_sync, Display_enable, H_pos, V_pos, Frame_start
`ifdef VGA_TIMING_CHECK_EN
      , output Config_err
`endif
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus combinational sync/visible/position decode.
module vga_axis_counter #(
   parameter int unsigned CountWidth  = 11,
   parameter int unsigned PulseWidth  = 8,
   parameter int unsigned MarginWidth = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   step_i,
   input  logic [CountWidth-1:0]  count_max_i,
   input  logic [PulseWidth-1:0]  pulse_i,
   input  logic [MarginWidth-1:0] left_i,
   input  logic [MarginWidth-1:0] right_i,
   output logic [CountWidth-1:0]  count_o,
   output logic                   last_o,
   output logic                   sync_o,
   output logic                   visible_o,
   output logic [CountWidth-1:0]  pos_o
);

   localparam int unsigned SumWidth = CountWidth + 1;

   logic [CountWidth-1:0] count_q, count_d;
   logic [SumWidth-1:0]   start, tail;

   assign count_o = count_q;
   assign last_o  = count_q >= count_max_i;

   always_comb begin
      count_d = count_q;
      if (step_i) begin
         count_d = last_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // One extra bit so porch sums and count+right never wrap; an oversize set just never shows.
   always_comb begin
      start     = SumWidth'(pulse_i) + SumWidth'(left_i);
      tail      = SumWidth'(count_q) + SumWidth'(right_i);
      sync_o    = SumWidth'(count_q) < SumWidth'(pulse_i);
      visible_o = (SumWidth'(count_q) >= start) && (tail <= SumWidth'(count_max_i));
      pos_o     = visible_o ? count_q - start[CountWidth-1:0] : '0;
   end

endmodule

// File: rtl/vga_timing.sv
// VGA sync/blanking generator; new timing is staged and takes effect at the frame boundary.
// Define VGA_TIMING_CHECK_EN to reject over-long configs and pulse Config_err.
module vga_timing #(
   parameter int unsigned REZ_MAX_WIDTH      = vga_timing_pkg::RezMaxWidthDef,
   parameter int unsigned PULSE_WIDTH        = vga_timing_pkg::PulseWidthDef,
   parameter int unsigned MARGIN_WIDTH       = vga_timing_pkg::MarginWidthDef,
   parameter bit          SYNC_ACTIVE        = 1'b0,
   parameter int unsigned RST_H_COUNT_MAX    = vga_timing_pkg::HCountMaxDef,
   parameter int unsigned RST_H_SYNC_PULSE   = vga_timing_pkg::HSyncPulseDef,
   parameter int unsigned RST_H_LEFT_MARGIN  = vga_timing_pkg::HLeftMarginDef,
   parameter int unsigned RST_H_RIGHT_MARGIN = vga_timing_pkg::HRightMarginDef,
   parameter int unsigned RST_V_COUNT_MAX    = vga_timing_pkg::VCountMaxDef,
   parameter int unsigned RST_V_SYNC_PULSE   = vga_timing_pkg::VSyncPulseDef,
   parameter int unsigned RST_V_LEFT_MARGIN  = vga_timing_pkg::VLeftMarginDef,
   parameter int unsigned RST_V_RIGHT_MARGIN = vga_timing_pkg::VRightMarginDef
) (
   input logic         Clk,
   input logic         Rst,
   vga_timing_if.slave bus
);

   import vga_timing_pkg::*;

   typedef struct packed {
      logic [REZ_MAX_WIDTH-1:0] h_max;
      logic [PULSE_WIDTH-1:0]   h_pulse;
      logic [MARGIN_WIDTH-1:0]  h_left;
      logic [MARGIN_WIDTH-1:0]  h_right;
      logic [REZ_MAX_WIDTH-1:0] v_max;
      logic [PULSE_WIDTH-1:0]   v_pulse;
      logic [MARGIN_WIDTH-1:0]  v_left;
      logic [MARGIN_WIDTH-1:0]  v_right;
   } cfg_t;

   localparam cfg_t CfgRst = '{
      h_max:   REZ_MAX_WIDTH'(RST_H_COUNT_MAX),
      h_pulse: PULSE_WIDTH'(RST_H_SYNC_PULSE),
      h_left:  MARGIN_WIDTH'(RST_H_LEFT_MARGIN),
      h_right: MARGIN_WIDTH'(RST_H_RIGHT_MARGIN),
      v_max:   REZ_MAX_WIDTH'(RST_V_COUNT_MAX),
      v_pulse: PULSE_WIDTH'(RST_V_SYNC_PULSE),
      v_left:  MARGIN_WIDTH'(RST_V_LEFT_MARGIN),
      v_right: MARGIN_WIDTH'(RST_V_RIGHT_MARGIN)
   };

   cfg_t cfg_in, active_q, active_d, shadow_q, shadow_d;
   logic pending_q, pending_d;
   logic load_ok, frame_end;

   logic                     h_last, v_last, h_sync, v_sync, h_vis, v_vis;
   logic [REZ_MAX_WIDTH-1:0] h_count, v_count, h_pos, v_pos;

   logic                     h_sync_q, v_sync_q, de_q, fs_q;
   logic [REZ_MAX_WIDTH-1:0] h_pos_q, v_pos_q;

   always_comb begin
      cfg_in.h_max   = bus.H_count_max;
      cfg_in.h_pulse = bus.H_sync_pulse;
      cfg_in.h_left  = bus.H_left_margin;
      cfg_in.h_right = bus.H_right_margin;
      cfg_in.v_max   = bus.V_count_max;
      cfg_in.v_pulse = bus.V_sync_pulse;
      cfg_in.v_left  = bus.V_left_margin;
      cfg_in.v_right = bus.V_right_margin;
   end

`ifdef VGA_TIMING_CHECK_EN
   logic cfg_bad, cfg_err_q;

   assign cfg_bad = !axis_fits(32'(cfg_in.h_max), 32'(cfg_in.h_pulse), 32'(cfg_in.h_left),
                               32'(cfg_in.h_right)) ||
                    !axis_fits(32'(cfg_in.v_max), 32'(cfg_in.v_pulse), 32'(cfg_in.v_left),
                               32'(cfg_in.v_right));
   assign load_ok = bus.Load_config && !cfg_bad;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= bus.Load_config && cfg_bad;
      end
   end

   assign bus.Config_err = cfg_err_q;
`else
   assign load_ok = bus.Load_config;
`endif

   assign frame_end = h_last && v_last;

   // A load landing on the frame-end cycle bypasses the shadow and goes live directly.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (load_ok) begin
         shadow_d  = cfg_in;
         pending_d = 1'b1;
      end
      if (frame_end && (load_ok || pending_q)) begin
         active_d  = load_ok ? cfg_in : shadow_q;
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         active_q  <= CfgRst;
         shadow_q  <= CfgRst;
         pending_q <= 1'b0;
      end else begin
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
      end
   end

   vga_axis_counter #(
      .CountWidth  (REZ_MAX_WIDTH),
      .PulseWidth  (PULSE_WIDTH),
      .MarginWidth (MARGIN_WIDTH)
   ) u_h_axis (
      .clk_i       (Clk),
      .rst_ni      (Rst),
      .step_i      (1'b1),
      .count_max_i (active_q.h_max),
      .pulse_i     (active_q.h_pulse),
      .left_i      (active_q.h_left),
      .right_i     (active_q.h_right),
      .count_o     (h_count),
      .last_o      (h_last),
      .sync_o      (h_sync),
      .visible_o   (h_vis),
      .pos_o       (h_pos)
   );

   vga_axis_counter #(
      .CountWidth  (REZ_MAX_WIDTH),
      .PulseWidth  (PULSE_WIDTH),
      .MarginWidth (MARGIN_WIDTH)
   ) u_v_axis (
      .clk_i       (Clk),
      .rst_ni      (Rst),
      .step_i      (h_last),
      .count_max_i (active_q.v_max),
      .pulse_i     (active_q.v_pulse),
      .left_i      (active_q.v_left),
      .right_i     (active_q.v_right),
      .count_o     (v_count),
      .last_o      (v_last),
      .sync_o      (v_sync),
      .visible_o   (v_vis),
      .pos_o       (v_pos)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         h_sync_q <= ~SYNC_ACTIVE;
         v_sync_q <= ~SYNC_ACTIVE;
         de_q     <= 1'b0;
         fs_q     <= 1'b0;
         h_pos_q  <= '0;
         v_pos_q  <= '0;
      end else begin
         h_sync_q <= h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         v_sync_q <= v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         de_q     <= h_vis && v_vis;
         fs_q     <= (h_count == '0) && (v_count == '0);
         h_pos_q  <= h_pos;
         v_pos_q  <= v_pos;
      end
   end

   assign bus.H_sync         = h_sync_q;
   assign bus.V_sync         = v_sync_q;
   assign bus.Display_enable = de_q;
   assign bus.Frame_start    = fs_q;
   assign bus.H_pos          = h_pos_q;
   assign bus.V_pos          = v_pos_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a 640x480 instance and a short-frame instance share stimulus.
module tb_vga_timing;

   typedef struct {
      int hmax; int hp; int hl; int hr;
      int vmax; int vp; int vl; int vr;
   } tcfg_t;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic        fs;
      logic        err;
      logic [10:0] hpos;
      logic [10:0] vpos;
   } exp_t;

   logic Clk;
   logic Rst;
   int   checks;
   int   failures;

   exp_t  sb0[$];
   exp_t  sb1[$];
   int    h_m[2];
   int    v_m[2];
   tcfg_t act_m[2];
   tcfg_t shd_m[2];
   tcfg_t rst_m[2];
   bit    pend_m[2];
   bit    sa_m[2];

   vga_timing_if bus0 ();
   vga_timing_if bus1 ();

   vga_timing u_dut_std (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus0)
   );

   vga_timing #(
      .SYNC_ACTIVE        (1'b1),
      .RST_H_COUNT_MAX    (15),
      .RST_H_SYNC_PULSE   (2),
      .RST_H_LEFT_MARGIN  (2),
      .RST_H_RIGHT_MARGIN (2),
      .RST_V_COUNT_MAX    (9),
      .RST_V_SYNC_PULSE   (1),
      .RST_V_LEFT_MARGIN  (1),
      .RST_V_RIGHT_MARGIN (1)
   ) u_dut_fast (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus1)
   );

   assign bus1.Load_config    = bus0.Load_config;
   assign bus1.H_count_max    = bus0.H_count_max;
   assign bus1.H_sync_pulse   = bus0.H_sync_pulse;
   assign bus1.H_left_margin  = bus0.H_left_margin;
   assign bus1.H_right_margin = bus0.H_right_margin;
   assign bus1.V_count_max    = bus0.V_count_max;
   assign bus1.V_sync_pulse   = bus0.V_sync_pulse;
   assign bus1.V_left_margin  = bus0.V_left_margin;
   assign bus1.V_right_margin = bus0.V_right_margin;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic bit cfg_bad(input tcfg_t c);
      return (c.hp + c.hl + c.hr > c.hmax) || (c.vp + c.vl + c.vr > c.vmax);
   endfunction

   function automatic bit rejected(input tcfg_t c);
`ifdef VGA_TIMING_CHECK_EN
      return cfg_bad(c);
`else
      return (c.hmax < 0);
`endif
   endfunction

   function automatic void model_reset(input int i);
      h_m[i]    = 0;
      v_m[i]    = 0;
      act_m[i]  = rst_m[i];
      shd_m[i]  = rst_m[i];
      pend_m[i] = 1'b0;
   endfunction

   function automatic exp_t reset_exp(input int i);
      exp_t e;
      e    = '0;
      e.hs = !sa_m[i];
      e.vs = !sa_m[i];
      return e;
   endfunction

   // Expected registered outputs for the counter position the next edge samples.
   function automatic exp_t model_out(input int i);
      exp_t  e;
      tcfg_t c;
      int    hst, vst;
      bit    hv, vv;
      c    = act_m[i];
      hst  = c.hp + c.hl;
      vst  = c.vp + c.vl;
      hv   = (h_m[i] >= hst) && (h_m[i] <= c.hmax - c.hr);
      vv   = (v_m[i] >= vst) && (v_m[i] <= c.vmax - c.vr);
      e    = '0;
      e.hs = (h_m[i] < c.hp) ? sa_m[i] : !sa_m[i];
      e.vs = (v_m[i] < c.vp) ? sa_m[i] : !sa_m[i];
      e.de = hv && vv;
      e.fs = (h_m[i] == 0) && (v_m[i] == 0);
      e.hpos = hv ? 11'(h_m[i] - hst) : 11'd0;
      e.vpos = vv ? 11'(v_m[i] - vst) : 11'd0;
      return e;
   endfunction

   function automatic void model_step(input int i, input logic load, input tcfg_t c);
      bit hw, fe;
      int old_vmax;
      old_vmax = act_m[i].vmax;
      hw = (h_m[i] == act_m[i].hmax);
      fe = hw && (v_m[i] == old_vmax);
      if (load && !rejected(c)) begin
         shd_m[i]  = c;
         pend_m[i] = 1'b1;
      end
      if (fe && pend_m[i]) begin
         act_m[i]  = shd_m[i];
         pend_m[i] = 1'b0;
      end
      if (hw) begin
         h_m[i] = 0;
         v_m[i] = (v_m[i] == old_vmax) ? 0 : v_m[i] + 1;
      end else begin
         h_m[i] = h_m[i] + 1;
      end
   endfunction

   function automatic bit at_frame_end(input int i);
      return (h_m[i] == act_m[i].hmax) && (v_m[i] == act_m[i].vmax);
   endfunction

   function automatic tcfg_t rand_cfg();
      tcfg_t c;
      c.hmax = int'($urandom_range(40, 6));
      c.hp   = int'($urandom_range(6, 0));
      c.hl   = int'($urandom_range(5, 0));
      c.hr   = int'($urandom_range(5, 0));
      c.vmax = int'($urandom_range(12, 3));
      c.vp   = int'($urandom_range(3, 0));
      c.vl   = int'($urandom_range(3, 0));
      c.vr   = int'($urandom_range(3, 0));
      return c;
   endfunction

   task automatic drive_cycle(input logic rst_n, input logic load, input tcfg_t c);
      exp_t e;
      @(negedge Clk);
      #1;
      Rst                 = rst_n;
      bus0.Load_config    = load;
      bus0.H_count_max    = 11'(c.hmax);
      bus0.H_sync_pulse   = 8'(c.hp);
      bus0.H_left_margin  = 8'(c.hl);
      bus0.H_right_margin = 8'(c.hr);
      bus0.V_count_max    = 11'(c.vmax);
      bus0.V_sync_pulse   = 8'(c.vp);
      bus0.V_left_margin  = 8'(c.vl);
      bus0.V_right_margin = 8'(c.vr);
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            model_reset(i);
            e = reset_exp(i);
         end else begin
            e = model_out(i);
`ifdef VGA_TIMING_CHECK_EN
            e.err = load && cfg_bad(c);
`endif
            model_step(i, load, c);
         end
         if (i == 0) sb0.push_back(e);
         else sb1.push_back(e);
      end
   endtask

   task automatic run_idle(input int n);
      for (int k = 0; k < n; k++) drive_cycle(1'b1, 1'b0, rand_cfg());
   endtask

   task automatic check1(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", name, idx, $time, got, want);
      end
   endtask

   function automatic exp_t sample(input int i);
      exp_t a;
      a = '0;
      if (i == 0) begin
         a.hs = bus0.H_sync; a.vs = bus0.V_sync; a.de = bus0.Display_enable;
         a.fs = bus0.Frame_start; a.hpos = bus0.H_pos; a.vpos = bus0.V_pos;
`ifdef VGA_TIMING_CHECK_EN
         a.err = bus0.Config_err;
`endif
      end else begin
         a.hs = bus1.H_sync; a.vs = bus1.V_sync; a.de = bus1.Display_enable;
         a.fs = bus1.Frame_start; a.hpos = bus1.H_pos; a.vpos = bus1.V_pos;
`ifdef VGA_TIMING_CHECK_EN
         a.err = bus1.Config_err;
`endif
      end
      return a;
   endfunction

   task automatic compare(input int i, input exp_t e);
      exp_t a;
      a = sample(i);
      check1("H_sync", i, 32'(a.hs), 32'(e.hs));
      check1("V_sync", i, 32'(a.vs), 32'(e.vs));
      check1("Display_enable", i, 32'(a.de), 32'(e.de));
      check1("Frame_start", i, 32'(a.fs), 32'(e.fs));
      check1("H_pos", i, 32'(a.hpos), 32'(e.hpos));
      check1("V_pos", i, 32'(a.vpos), 32'(e.vpos));
`ifdef VGA_TIMING_CHECK_EN
      check1("Config_err", i, 32'(a.err), 32'(e.err));
`endif
   endtask

   // Monitor: every negedge the outputs of the preceding rising edge are due.
   always @(negedge Clk) begin
      if (sb0.size() != 0) compare(0, sb0.pop_front());
      if (sb1.size() != 0) compare(1, sb1.pop_front());
   end

   initial begin
      tcfg_t c;
      checks   = 0;
      failures = 0;
      rst_m[0] = '{799, 96, 48, 16, 524, 2, 33, 10};
      rst_m[1] = '{15, 2, 2, 2, 9, 1, 1, 1};
      sa_m[0]  = 1'b0;
      sa_m[1]  = 1'b1;
      model_reset(0);
      model_reset(1);
      Rst = 1'b0;
      bus0.Load_config = 1'b0;
      c = rst_m[1];

      for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b0, c);
      // Two full 640x480 lines, many short frames.
      run_idle(1700);

      c = '{9, 2, 1, 1, 5, 1, 1, 1};
      drive_cycle(1'b1, 1'b1, c);
      run_idle(400);

      c = '{12, 1, 2, 3, 6, 1, 1, 1};
      drive_cycle(1'b1, 1'b1, c);
      run_idle(5);
      c = '{20, 3, 4, 2, 7, 2, 1, 1};
      drive_cycle(1'b1, 1'b1, c);
      run_idle(300);

      for (int k = 0; k < 1000 && !at_frame_end(1); k++) drive_cycle(1'b1, 1'b0, rand_cfg());
      c = '{11, 1, 1, 1, 4, 1, 0, 0};
      drive_cycle(1'b1, 1'b1, c);
      run_idle(200);

      c = '{9, 6, 3, 3, 5, 1, 1, 1};
      drive_cycle(1'b1, 1'b1, c);
      run_idle(200);

      // Pending set dropped by a mid-frame reset.
      c = '{14, 2, 1, 1, 6, 1, 1, 1};
      drive_cycle(1'b1, 1'b1, c);
      run_idle(7);
      drive_cycle(1'b0, 1'b0, c);
      drive_cycle(1'b0, 1'b0, c);
      run_idle(400);

      for (int k = 0; k < 4000; k++) begin
         drive_cycle(1'b1, $urandom_range(39, 0) == 0, rand_cfg());
      end

      @(negedge Clk);
      #2;
      check1("scoreboard_drain", 0, 32'(sb0.size() + sb1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
